matrix_operand_loader: RTL and testbench
========================================

MATRIX_OPERAND_LOADER -- requirements
Module: matrix_operand_loader

Interface
REQ-001 Parameter M, default 2: rows of A.
REQ-002 Parameter K, default 2: columns of A and rows of B.
REQ-003 Parameter N, default 2: columns of B.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_valid  input  1  upstream operand word valid.
REQ-007 s_ready  output  1  loader can accept a word.
REQ-008 s_data  input  32  operand word, IEEE-754 single; treated as opaque bits.
REQ-009 s_last  input  1  marks final word of a frame (A words then B words).
REQ-010 matrix_A  output  32 x M*K  A operands, row-major, element r*K+c.
REQ-011 matrix_B  output  32 x K*N  B operands, row-major, element r*N+c.
REQ-012 mm_start  output  1  one-cycle start pulse to the matrix multiply engine.
REQ-013 mm_done  input  1  engine completion pulse.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 frame_err  output  1  one-cycle pulse on a malformed frame.

Function
REQ-016 A word transfers on a rising edge with s_valid=1 and s_ready=1; no other edge changes the word counter or buffers.
REQ-017 States are IDLE, LOAD_A, LOAD_B, FIRE and WAIT.
REQ-018 s_ready is 1 in IDLE, LOAD_A and LOAD_B, and 0 in FIRE and WAIT.
REQ-019 IDLE: an accepted word is written to matrix_A[0], the counter becomes 1, and the state moves to LOAD_A; if M*K=1 the state moves to LOAD_B instead.
REQ-020 LOAD_A: accepted word n (n = counter value) is written to matrix_A[n]; after word M*K-1 the counter resets to 0 and the state moves to LOAD_B.
REQ-021 LOAD_B: accepted word n is written to matrix_B[n]; after word K*N-1 the state moves to FIRE.
REQ-022 The counter is 16 bits wide; M*K and K*N are each at most 65535.
REQ-023 FIRE: mm_start=1 for exactly that cycle, then the state moves to WAIT.
REQ-024 mm_start is 1 only in the FIRE state.
REQ-025 WAIT: matrix_A and matrix_B are held stable; on mm_done=1 the state moves to IDLE on the next edge.
REQ-026 mm_done is ignored in every state except WAIT.
REQ-027 The next frame is accepted in IDLE starting one cycle after mm_done, with no added bubble beyond the IDLE cycle.
REQ-028 Frame length is M*K+K*N words; s_last is expected only on the final B word.
REQ-029 s_last=1 on any earlier accepted word: frame_err pulses, the counter clears, the state moves to IDLE, and the buffers keep their partial contents; no mm_start is issued.
REQ-030 s_last=0 on the final B word: frame_err pulses, the state returns to IDLE, and no mm_start is issued.
REQ-031 frame_err lasts one cycle and is registered, asserting on the cycle after the offending transfer.
REQ-032 A word is never dropped or duplicated while s_valid stays high across state changes; back-to-back words are accepted at one per cycle.
REQ-033 All outputs are driven from registers; s_ready is a registered or pure decode of state only, with no combinational path from s_valid.

Reset
REQ-034 rst_n=0 forces, at any time including mid-frame or in WAIT: state=IDLE, counter=0, all matrix_A/matrix_B elements=0, mm_start=0, frame_err=0, busy=0.
REQ-035 s_ready=1 from the first edge after rst_n deasserts.
REQ-036 A reset during WAIT abandons the operation; a later mm_done is ignored.

Verification
REQ-037 M=K=N=2, stream 0x3F800000, 0x40000000, 0x40400000, 0x40800000 (A), then 0x40A00000, 0x40C00000, 0x40E00000, 0x41000000 (B) with s_last on the 8th word -> matrix_A and matrix_B hold the words in order; mm_start pulses once, the cycle after the 8th transfer; busy=1 until mm_done.
REQ-038 Same frame with s_valid toggling 1/0 every cycle -> identical buffer contents; 8 transfers; one mm_start.
REQ-039 s_last on the 3rd word -> frame_err pulse, state IDLE, no mm_start; the next full frame loads correctly.
REQ-040 Full frame with s_last=0 on the 8th word -> frame_err pulse, no mm_start.
REQ-041 In WAIT, hold s_valid=1 -> s_ready=0 and no buffer change; mm_done pulse -> IDLE, then a new frame is accepted.
REQ-042 rst_n pulsed low after the 5th word -> all outputs and buffers 0; the subsequent 8-word frame loads from matrix_A[0].

Source files
------------

// File: rtl/matrix_operand_loader.sv
// Streams one frame of A then B operand words into row-major buffers, then
// starts the matrix multiply engine and holds the operands until it reports done.
// A malformed frame (early or missing s_last) raises a one-cycle frame_err and
// returns to IDLE without starting the engine.
//
// state  | meaning
// IDLE   | waiting for the first A word of a frame
// LOAD_A | collecting A words 1 .. M*K-1
// LOAD_B | collecting B words 0 .. K*N-1
// FIRE   | mm_start high for this single cycle
// WAIT   | operands frozen until mm_done
module matrix_operand_loader #(
  parameter int M = 2,
  parameter int K = 2,
  parameter int N = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic [31:0] matrix_A [M*K],
  output logic [31:0] matrix_B [K*N],
  output logic        mm_start,
  input  logic        mm_done,
  output logic        busy,
  output logic        frame_err
);

  localparam int NA = M * K;
  localparam int NB = K * N;
  localparam int AW = (NA > 1) ? $clog2(NA) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [15:0] LAST_A = 16'(NA - 1);
  localparam logic [15:0] LAST_B = 16'(NB - 1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, FIRE, WAIT} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        xfer;

  // s_ready is a registered copy of "state accepts words", so xfer never
  // depends combinationally on s_valid through the ready path.
  assign xfer = s_valid & s_ready;

  // Sequencing FSM; s_ready and busy are updated together with every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mm_start  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      s_ready   <= 1'b1;
    end else begin
      mm_start  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (s_last) begin
              // A frame always has at least two words, so s_last here is early.
              frame_err <= 1'b1;
              cnt       <= '0;
            end else if (NA == 1) begin
              state <= LOAD_B;
              cnt   <= '0;
              busy  <= 1'b1;
            end else begin
              state <= LOAD_A;
              cnt   <= 16'd1;
              busy  <= 1'b1;
            end
          end
        end
        LOAD_A: begin
          if (xfer) begin
            if (s_last) begin
              state     <= IDLE;
              cnt       <= '0;
              frame_err <= 1'b1;
              busy      <= 1'b0;
            end else if (cnt == LAST_A) begin
              state <= LOAD_B;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        LOAD_B: begin
          if (xfer) begin
            if (cnt == LAST_B) begin
              cnt <= '0;
              if (s_last) begin
                state    <= FIRE;
                mm_start <= 1'b1;
                s_ready  <= 1'b0;
              end else begin
                state     <= IDLE;
                frame_err <= 1'b1;
                busy      <= 1'b0;
              end
            end else if (s_last) begin
              state     <= IDLE;
              cnt       <= '0;
              frame_err <= 1'b1;
              busy      <= 1'b0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        FIRE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mm_done) begin
            state   <= IDLE;
            busy    <= 1'b0;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          busy    <= 1'b0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

  // Operand buffers: only accepted words write, so FIRE/WAIT leave them frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NA; i++) matrix_A[i] <= '0;
      for (int j = 0; j < NB; j++) matrix_B[j] <= '0;
    end else if (xfer) begin
      if (state == IDLE || state == LOAD_A) begin
        matrix_A[cnt[AW-1:0]] <= s_data;
      end else if (state == LOAD_B) begin
        matrix_B[cnt[BW-1:0]] <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed sequence with random operand words for matrix_operand_loader (M=K=N=2).
// Expected buffer contents come from a frame-level model: the i-th accepted word
// of a frame lands in A[i] for i < M*K, otherwise in B[i-M*K].
module tb_matrix_operand_loader;

  localparam int M  = 2;
  localparam int K  = 2;
  localparam int N  = 2;
  localparam int NA = M * K;
  localparam int NB = K * N;
  localparam int FL = NA + NB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [31:0] matrix_A [NA];
  logic [31:0] matrix_B [NB];
  logic        mm_start;
  logic        mm_done;
  logic        busy;
  logic        frame_err;

  matrix_operand_loader #(.M(M), .K(K), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .matrix_A (matrix_A),
    .matrix_B (matrix_B),
    .mm_start (mm_start),
    .mm_done  (mm_done),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Event counters observed at the active edge (pre-update values).
  int xfers  = 0;
  int starts = 0;
  int errs   = 0;
  always @(posedge clk) begin
    if (rst_n && s_valid && s_ready) xfers++;
    if (mm_start) starts++;
    if (frame_err) errs++;
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_A [NA];
  logic [31:0] exp_B [NB];
  logic [31:0] w [FL];
  int x0, s0, e0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bufs(input string tag);
    for (int i = 0; i < NA; i++) check($sformatf("%s_A%0d", tag, i), matrix_A[i], exp_A[i]);
    for (int i = 0; i < NB; i++) check($sformatf("%s_B%0d", tag, i), matrix_B[i], exp_B[i]);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NA; i++) exp_A[i] = '0;
    for (int i = 0; i < NB; i++) exp_B[i] = '0;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < FL; i++) w[i] = $urandom;
  endtask

  task automatic snap();
    x0 = xfers; s0 = starts; e0 = errs;
  endtask

  // Presents one word from a negedge; returns just after the accepting posedge.
  task automatic send_word(input logic [31:0] d, input logic last);
    int guard;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    guard   = 0;
    while (!s_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) check("ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
  endtask

  // Sends n words of w; last_pos is the 1-based word carrying s_last (0 = none).
  task automatic send_frame(input int n, input int last_pos, input bit toggle);
    for (int i = 0; i < n; i++) begin
      send_word(w[i], (i + 1 == last_pos));
      if (i < NA) exp_A[i] = w[i];
      else exp_B[i - NA] = w[i];
      if (toggle && i + 1 < n) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    mm_done = 1'b1;
    @(negedge clk);
    mm_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; mm_done = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(mm_start), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check_bufs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(s_ready), 32'd1);

    // Directed frame with the listed float words.
    for (int i = 0; i < FL; i++) w[i] = 32'h3F80_0000 + 32'(i == 0 ? 0 : 0);
    w[0] = 32'h3F800000; w[1] = 32'h40000000; w[2] = 32'h40400000; w[3] = 32'h40800000;
    w[4] = 32'h40A00000; w[5] = 32'h40C00000; w[6] = 32'h40E00000; w[7] = 32'h41000000;
    snap();
    send_frame(FL, FL, 1'b0);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("d_start_fire", 32'(mm_start), 32'd1);
    check("d_busy_fire", 32'(busy), 32'd1);
    check("d_ready_fire", 32'(s_ready), 32'd0);
    check_bufs("d");
    @(negedge clk);
    check("d_start_wait", 32'(mm_start), 32'd0);
    check("d_busy_wait", 32'(busy), 32'd1);
    // Valid held high in WAIT must not move anything.
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = $urandom;
      @(negedge clk);
      check("wait_ready", 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    check_bufs("wait");
    check("d_xfers", 32'(xfers - x0), 32'd8);
    pulse_done();
    check("d_done_busy", 32'(busy), 32'd0);
    check("d_done_ready", 32'(s_ready), 32'd1);
    check("d_starts", 32'(starts - s0), 32'd1);
    check("d_errs", 32'(errs - e0), 32'd0);

    // Random frame with s_valid toggling every cycle.
    rand_frame();
    snap();
    send_frame(FL, FL, 1'b1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("t_start_fire", 32'(mm_start), 32'd1);
    check_bufs("t");
    check("t_xfers", 32'(xfers - x0), 32'd8);
    pulse_done();
    check("t_starts", 32'(starts - s0), 32'd1);
    check("t_idle", 32'(busy), 32'd0);

    // Early s_last on the 3rd word.
    rand_frame();
    snap();
    send_frame(3, 3, 1'b0);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("e3_err", 32'(frame_err), 32'd1);
    check("e3_busy", 32'(busy), 32'd0);
    check("e3_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    check("e3_err_1cyc", 32'(frame_err), 32'd0);
    check_bufs("e3");
    repeat (3) @(negedge clk);
    check("e3_starts", 32'(starts - s0), 32'd0);
    rand_frame();
    snap();
    send_frame(FL, FL, 1'b0);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("e3n_start", 32'(mm_start), 32'd1);
    check_bufs("e3n");
    pulse_done();
    check("e3n_starts", 32'(starts - s0), 32'd1);

    // Missing s_last on the final B word.
    rand_frame();
    snap();
    send_frame(FL, 0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("nl_err", 32'(frame_err), 32'd1);
    check("nl_start", 32'(mm_start), 32'd0);
    check("nl_busy", 32'(busy), 32'd0);
    check_bufs("nl");
    repeat (3) @(negedge clk);
    check("nl_starts", 32'(starts - s0), 32'd0);
    check("nl_errs", 32'(errs - e0), 32'd1);

    // mm_done outside WAIT is ignored.
    snap();
    pulse_done();
    check("idle_done_busy", 32'(busy), 32'd0);
    check("idle_done_start", 32'(starts - s0), 32'd0);

    // Reset after the 5th word, then a fresh frame from A[0].
    rand_frame();
    send_frame(5, 0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_bufs("mr");
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_err", 32'(frame_err), 32'd0);
    check("mr_start", 32'(mm_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_ready", 32'(s_ready), 32'd1);
    rand_frame();
    snap();
    send_frame(FL, FL, 1'b0);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("mr_fire", 32'(mm_start), 32'd1);
    check_bufs("mrf");

    // Reset while in WAIT abandons the operation; a later mm_done does nothing.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    check("wr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    snap();
    pulse_done();
    check("wr_done_busy", 32'(busy), 32'd0);
    check("wr_done_ready", 32'(s_ready), 32'd1);
    check("wr_starts", 32'(starts - s0), 32'd0);
    check_bufs("wr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
